dmem_copy_engine: RTL and testbench
===================================

Name: dmem_copy_engine

Overview:
Bus initiator for the single-port, word-addressed data memory (combinational read, synchronous write on mem_write).
- Performs block operations on a word range: COPY (src to dst), FILL (constant to dst) and SUM (32-bit additive checksum of a src range).
- Drives address/write_data/mem_write and samples read_data.
- Sits beside the CPU datapath; a muxing layer grants it the memory port while busy=1.

Parameters:
DATA_W, 32, memory word width
ADDR_W, 8, significant word-address bits
DEPTH, 256, number of valid words (indices 0..DEPTH-1)
DEBUG_IN_ADDR, 255, word the memory overrides with debug input on write; never a legal write target

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
mode  in  2  0=COPY, 1=FILL, 2=SUM, 3=reserved (rejected)
src_addr  in  ADDR_W  first source word
dst_addr  in  ADDR_W  first destination word
length  in  ADDR_W+1  word count, 0..DEPTH
fill_value  in  DATA_W  FILL constant
busy  out  1  high while the engine owns the memory port
done  out  1  one-cycle completion pulse
error  out  1  one-cycle rejection pulse
checksum  out  DATA_W  SUM result; holds until the next SUM start
address  out  32  memory word address, zero-extended
write_data  out  DATA_W  memory write data
mem_write  out  1  memory write strobe
read_data  in  DATA_W  combinational memory read data

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; busy, done, error, mem_write = 0; address, write_data, checksum = 0. Reset mid-operation drops the access immediately; no done or error pulse.
- IDLE outputs: address=0, write_data=0, mem_write=0.
- Start acceptance: start is honoured only in IDLE. In any other state it is ignored.
- Parameters are latched on the accepted start edge.
- Rejection (error=1 for one cycle next cycle, no memory access, back to IDLE) when any of these hold:
  - mode=3
  - COPY/SUM: src_addr+length > DEPTH
  - COPY/FILL: dst_addr+length > DEPTH
  - COPY/FILL: the dst range contains DEBUG_IN_ADDR
- length=0 with legal mode: done pulses the next cycle; no access; SUM gives checksum=0.
- States: IDLE, RD, WR, FILL, SUM, DONE. busy=1 in RD, WR, FILL and SUM only.
- COPY:
  - RD drives address=src index and latches read_data into a holding register.
  - WR drives address=dst index, write_data=held word, mem_write=1.
  - 2 cycles per word. Start at cycle 0, accesses in cycles 1..2N, done in cycle 2N+1.
- COPY direction:
  - If dst_addr > src_addr, indices run descending from offset length-1 to 0.
  - Otherwise they run ascending.
  - Overlapping ranges therefore copy correctly. dst=src performs a rewrite of identical data.
- FILL: one write per cycle (address=dst+i, write_data=fill_value, mem_write=1), ascending. Done in cycle N+1.
- SUM:
  - One read per cycle, mem_write=0.
  - Accumulator is cleared at start and adds read_data modulo 2^DATA_W.
  - checksum updates on the DONE cycle. Done in cycle N+1.
- mem_write is asserted only in WR and FILL, never in IDLE, RD, SUM or DONE.
- Index counter is ADDR_W+1 bits wide, so length=DEPTH terminates without wrap. Addresses never wrap past DEPTH-1.
- DONE: done=1, busy=0, mem_write=0. Next state IDLE, so a new start is accepted the cycle after done.

Decomposition:
- Shared package dmem_pkg holds: mode encodings (MODE_COPY, MODE_FILL, MODE_SUM), state enum, DEPTH, DEBUG_IN_ADDR.
- One natural sub-module: dmem_range_check. It is combinational and produces legal/illegal from mode, src, dst and length.
- FSM, counter and datapath stay in the top.

Test Plan:
- Memory preloaded mem[i]=i; COPY src=10 dst=20 len=4 -> mem[20..23]=10..13; mem_write high on exactly 4 cycles; done at cycle 9 after start.
- mem[i]=i; COPY src=10 dst=12 len=4 (overlap, descending) -> mem[12..15]=10..13; address sequence 13,15,12,14,11,13,10,12.
- FILL dst=0 len=256 -> error pulse, no writes (range contains 255).
- FILL dst=100 len=3 value=32'hDEADBEEF -> mem[100..102]=DEADBEEF; done at cycle 4.
- mem[i]=i; SUM src=0 len=255 -> checksum=32385; mem_write never asserted.
- Edge cases -> each independently as follows:
  - COPY len=0: done next cycle, no access.
  - mode=3: error pulse.
  - start while busy: ignored.
  - rst_n=0 mid-COPY after 2 words: only dst+0 and dst+1 written; outputs zero; no done.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_pkg : shared constants, mode encodings and FSM states for the dmem copy engine
// Revision : 1.0
// ---------------------------------------------------------------------------
package dmem_pkg;

  localparam int DMEM_DEPTH         = 256;
  localparam int DMEM_DEBUG_IN_ADDR = 255;

  localparam logic [1:0] MODE_COPY = 2'd0;
  localparam logic [1:0] MODE_FILL = 2'd1;
  localparam logic [1:0] MODE_SUM  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_FILL = 3'd3,
    ST_SUM  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_range_check.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_range_check : combinational legality check of a requested block operation
// Revision : 1.0
// ---------------------------------------------------------------------------
module dmem_range_check
  import dmem_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int DEPTH         = DMEM_DEPTH,
  parameter int DEBUG_IN_ADDR = DMEM_DEBUG_IN_ADDR
) (
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  output logic              legal
);

  // Two spare bits so base+length never overflows before comparison.
  localparam int            EW      = ADDR_W + 2;
  localparam logic [EW-1:0] DEPTH_E = EW'(DEPTH);
  localparam logic [EW-1:0] DBG_E   = EW'(DEBUG_IN_ADDR);

  logic [EW-1:0] src_end;
  logic [EW-1:0] dst_beg;
  logic [EW-1:0] dst_end;
  logic          uses_src;
  logic          uses_dst;
  logic          src_bad;
  logic          dst_bad;
  logic          dbg_hit;

  always_comb begin
    dst_beg  = EW'(dst_addr);
    src_end  = EW'(src_addr) + EW'(length);
    dst_end  = dst_beg + EW'(length);
    uses_src = (mode == MODE_COPY) || (mode == MODE_SUM);
    uses_dst = (mode == MODE_COPY) || (mode == MODE_FILL);
    src_bad  = uses_src && (src_end > DEPTH_E);
    dst_bad  = uses_dst && (dst_end > DEPTH_E);
    dbg_hit  = uses_dst && (dst_beg <= DBG_E) && (DBG_E < dst_end);
    legal    = (mode != MODE_RSVD) && !src_bad && !dst_bad && !dbg_hit;
  end

endmodule
`default_nettype wire

// File: rtl/dmem_copy_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_copy_engine : memory-port initiator performing COPY / FILL / SUM on word ranges
// Revision : 1.0
// ---------------------------------------------------------------------------
module dmem_copy_engine
  import dmem_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 8,
  parameter int DEPTH         = DMEM_DEPTH,
  parameter int DEBUG_IN_ADDR = DMEM_DEBUG_IN_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum,
  output logic [31:0]       address,
  output logic [DATA_W-1:0] write_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] read_data
);

  localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] IDX_ZERO = '0;

  state_e              state_q,      state_d;
  logic [ADDR_W-1:0]   src_q,        src_d;
  logic [ADDR_W-1:0]   dst_q,        dst_d;
  logic [ADDR_W:0]     len_q,        len_d;
  logic [ADDR_W:0]     idx_q,        idx_d;
  logic                desc_q,       desc_d;
  logic [DATA_W-1:0]   fill_q,       fill_d;
  logic [DATA_W-1:0]   acc_q,        acc_d;
  logic [DATA_W-1:0]   checksum_q,   checksum_d;
  logic [31:0]         address_q,    address_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic                mem_write_q,  mem_write_d;
  logic                busy_q,       busy_d;
  logic                done_q,       done_d;
  logic                error_q,      error_d;

  logic                legal;
  logic                start_desc;
  logic [ADDR_W:0]     idx_nx;
  logic [DATA_W-1:0]   acc_nx;

  dmem_range_check #(
    .ADDR_W        (ADDR_W),
    .DEPTH         (DEPTH),
    .DEBUG_IN_ADDR (DEBUG_IN_ADDR)
  ) u_range_check (
    .mode     (mode),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .legal    (legal)
  );

  // Descending order keeps overlapping COPY correct when dst lies above src.
  function automatic logic [ADDR_W:0] word_off(input logic            desc,
                                               input logic [ADDR_W:0] len,
                                               input logic [ADDR_W:0] i);
    return desc ? (len - i - IDX_ONE) : i;
  endfunction

  function automatic logic [31:0] word_addr(input logic [ADDR_W-1:0] base,
                                            input logic [ADDR_W:0]   off);
    logic [ADDR_W:0] sum;
    sum = {1'b0, base} + off;
    return 32'(sum);
  endfunction

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    idx_d        = idx_q;
    desc_d       = desc_q;
    fill_d       = fill_q;
    acc_d        = acc_q;
    checksum_d   = checksum_q;
    address_d    = '0;
    write_data_d = '0;
    mem_write_d  = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    error_d      = 1'b0;
    idx_nx       = idx_q + IDX_ONE;
    acc_nx       = acc_q + read_data;
    start_desc   = (mode == MODE_COPY) && (dst_addr > src_addr);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          len_d  = length;
          fill_d = fill_value;
          desc_d = start_desc;
          idx_d  = IDX_ZERO;
          acc_d  = '0;
          if (!legal) begin
            error_d = 1'b1;
          end else if (length == IDX_ZERO) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            if (mode == MODE_SUM) checksum_d = '0;
          end else begin
            busy_d = 1'b1;
            case (mode)
              MODE_COPY: begin
                state_d   = ST_RD;
                address_d = word_addr(src_addr, word_off(start_desc, length, IDX_ZERO));
              end
              MODE_FILL: begin
                state_d      = ST_FILL;
                address_d    = word_addr(dst_addr, IDX_ZERO);
                write_data_d = fill_value;
                mem_write_d  = 1'b1;
              end
              default: begin
                state_d   = ST_SUM;
                address_d = word_addr(src_addr, IDX_ZERO);
              end
            endcase
          end
        end
      end

      // write_data_q doubles as the holding register for the word just read.
      ST_RD: begin
        state_d      = ST_WR;
        busy_d       = 1'b1;
        address_d    = word_addr(dst_q, word_off(desc_q, len_q, idx_q));
        write_data_d = read_data;
        mem_write_d  = 1'b1;
      end

      ST_WR: begin
        if (idx_nx == len_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d   = ST_RD;
          idx_d     = idx_nx;
          busy_d    = 1'b1;
          address_d = word_addr(src_q, word_off(desc_q, len_q, idx_nx));
        end
      end

      ST_FILL: begin
        if (idx_nx == len_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d        = idx_nx;
          busy_d       = 1'b1;
          address_d    = word_addr(dst_q, idx_nx);
          write_data_d = fill_q;
          mem_write_d  = 1'b1;
        end
      end

      ST_SUM: begin
        acc_d = acc_nx;
        if (idx_nx == len_q) begin
          state_d    = ST_DONE;
          done_d     = 1'b1;
          checksum_d = acc_nx;
        end else begin
          idx_d     = idx_nx;
          busy_d    = 1'b1;
          address_d = word_addr(src_q, idx_nx);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      desc_q       <= 1'b0;
      fill_q       <= '0;
      acc_q        <= '0;
      checksum_q   <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      mem_write_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      desc_q       <= desc_d;
      fill_q       <= fill_d;
      acc_q        <= acc_d;
      checksum_q   <= checksum_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      mem_write_q  <= mem_write_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign checksum   = checksum_q;
  assign address    = address_q;
  assign write_data = write_data_q;
  assign mem_write  = mem_write_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_copy_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_copy_engine : scoreboard bench with a behavioural memory for dmem_copy_engine
// Revision : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_copy_engine;
  import dmem_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic [ADDR_W:0]   length = '0;
  logic [DATA_W-1:0] fill_value = '0;
  logic              busy, done, error, mem_write;
  logic [DATA_W-1:0] checksum, write_data, read_data;
  logic [31:0]       address;

  logic [DATA_W-1:0] mem [0:255];
  logic              preload_req = 1'b0;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  addr_log[$];
  int  checks = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  dmem_copy_engine #(
    .DATA_W        (DATA_W),
    .ADDR_W        (ADDR_W),
    .DEPTH         (256),
    .DEBUG_IN_ADDR (255)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .fill_value (fill_value),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .checksum   (checksum),
    .address    (address),
    .write_data (write_data),
    .mem_write  (mem_write),
    .read_data  (read_data)
  );

  assign read_data = mem[address[ADDR_W-1:0]];

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
    end else if (mem_write) begin
      mem[address[ADDR_W-1:0]] <= write_data;
    end
  end

  task automatic preload();
    @(negedge clk) preload_req = 1'b1;
    @(negedge clk) preload_req = 1'b0;
  endtask

  task automatic push_wr(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Issues one start and monitors until done/error; cycle 1 is the cycle after the start edge.
  task automatic run_op(input logic [1:0] m, input int s, input int d, input int n,
                        input logic [31:0] fv, input int intrude_cyc,
                        output int done_cyc, output int err_cyc, output int n_wr,
                        output logic [31:0] cs_at_done);
    bit  fin;
    wr_t e;
    done_cyc = -1; err_cyc = -1; n_wr = 0; cs_at_done = '0; fin = 1'b0;
    addr_log.delete();
    @(negedge clk);
    mode = m; src_addr = ADDR_W'(s); dst_addr = ADDR_W'(d);
    length = (ADDR_W + 1)'(n); fill_value = fv; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c <= 600 && !fin; c++) begin
      if (busy) addr_log.push_back(int'(address));
      if (mem_write) begin
        n_wr++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write cycle=%0d addr=%0d data=%h required=none", c, address, write_data);
        end else begin
          e = exp_q.pop_front();
          if (address !== 32'(e.addr) || write_data !== e.data) begin
            failures++;
            $display("FAIL write_seq cycle=%0d got addr=%0d data=%h required addr=%0d data=%h",
                     c, address, write_data, e.addr, e.data);
          end
        end
      end
      if (done) begin done_cyc = c; cs_at_done = checksum; fin = 1'b1; end
      if (error) begin err_cyc = c; fin = 1'b1; end
      if (!fin) begin
        if (c == intrude_cyc) begin
          mode = MODE_COPY; src_addr = 8'd0; dst_addr = 8'd200; length = 9'd2; start = 1'b1;
        end
        @(posedge clk); #1; start = 1'b0;
      end
    end
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL timeout got=no_done_or_error required=completion");
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_writes got=%0d_pending required=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_int(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic chk_mem(input string name, input int a, input logic [31:0] req);
    checks++;
    if (mem[a] !== req) begin
      failures++;
      $display("FAIL %s mem[%0d] got=%h required=%h", name, a, mem[a], req);
    end
  endtask

  int          dc, ec, nw;
  logic [31:0] cs;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, error, mem_write} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b required=0000", {busy, done, error, mem_write});
    end
    checks++;
    if (address !== 32'd0 || write_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_bus got addr=%h data=%h required 0", address, write_data);
    end
    checks++;
    if (checksum !== 32'd0) begin
      failures++;
      $display("FAIL reset_checksum got=%h required=0", checksum);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_copy();
    preload();
    for (int i = 3; i >= 0; i--) push_wr(20 + i, 32'(10 + i));
    run_op(MODE_COPY, 10, 20, 4, '0, 0, dc, ec, nw, cs);
    chk_int("copy_done_cycle", dc, 9);
    chk_int("copy_writes", nw, 4);
    for (int i = 0; i < 4; i++) chk_mem("copy_data", 20 + i, 32'(10 + i));
  endtask

  task automatic test_copy_overlap();
    int req_seq[8] = '{13, 15, 12, 14, 11, 13, 10, 12};
    preload();
    for (int i = 3; i >= 0; i--) push_wr(12 + i, 32'(10 + i));
    run_op(MODE_COPY, 10, 12, 4, '0, 0, dc, ec, nw, cs);
    chk_int("overlap_done_cycle", dc, 9);
    chk_int("overlap_addr_count", addr_log.size(), 8);
    for (int i = 0; i < 8 && i < addr_log.size(); i++) chk_int("overlap_addr_seq", addr_log[i], req_seq[i]);
    for (int i = 0; i < 4; i++) chk_mem("overlap_data", 12 + i, 32'(10 + i));
  endtask

  task automatic test_copy_ascending();
    preload();
    for (int i = 0; i < 3; i++) push_wr(18 + i, 32'(20 + i));
    run_op(MODE_COPY, 20, 18, 3, '0, 0, dc, ec, nw, cs);
    chk_int("asc_done_cycle", dc, 7);
    for (int i = 0; i < 3; i++) chk_mem("asc_data", 18 + i, 32'(20 + i));
  endtask

  task automatic test_fill();
    run_op(MODE_FILL, 0, 0, 256, 32'h1234_5678, 0, dc, ec, nw, cs);
    chk_int("fill_debug_error_cycle", ec, 1);
    chk_int("fill_debug_writes", nw, 0);
    chk_int("fill_debug_busy_cycles", addr_log.size(), 0);
    for (int i = 0; i < 3; i++) push_wr(100 + i, 32'hDEAD_BEEF);
    run_op(MODE_FILL, 0, 100, 3, 32'hDEAD_BEEF, 0, dc, ec, nw, cs);
    chk_int("fill_done_cycle", dc, 4);
    for (int i = 0; i < 3; i++) chk_mem("fill_data", 100 + i, 32'hDEAD_BEEF);
  endtask

  task automatic test_sum();
    preload();
    run_op(MODE_SUM, 0, 0, 255, '0, 0, dc, ec, nw, cs);
    chk_int("sum_done_cycle", dc, 256);
    chk_int("sum_checksum", int'(cs), 32385);
    chk_int("sum_writes", nw, 0);
    chk_int("sum_checksum_hold", int'(checksum), 32385);
  endtask

  task automatic test_edge_cases();
    run_op(MODE_COPY, 10, 20, 0, '0, 0, dc, ec, nw, cs);
    chk_int("len0_done_cycle", dc, 1);
    chk_int("len0_busy_cycles", addr_log.size(), 0);
    run_op(MODE_SUM, 5, 0, 0, '0, 0, dc, ec, nw, cs);
    chk_int("sum_len0_checksum", int'(cs), 0);
    run_op(MODE_RSVD, 0, 0, 1, '0, 0, dc, ec, nw, cs);
    chk_int("mode3_error_cycle", ec, 1);
    chk_int("mode3_done", dc, -1);
    run_op(MODE_COPY, 200, 0, 57, '0, 0, dc, ec, nw, cs);
    chk_int("src_overrun_error_cycle", ec, 1);
    push_wr(254, 32'h0000_0005);
    run_op(MODE_FILL, 0, 254, 1, 32'h0000_0005, 0, dc, ec, nw, cs);
    chk_int("fill_254_done_cycle", dc, 2);
    chk_int("fill_254_error", ec, -1);
  endtask

  task automatic test_start_while_busy();
    preload();
    for (int i = 0; i < 4; i++) push_wr(50 + i, 32'hA5A5_0001);
    run_op(MODE_FILL, 0, 50, 4, 32'hA5A5_0001, 2, dc, ec, nw, cs);
    chk_int("busy_start_done_cycle", dc, 5);
    chk_int("busy_start_error", ec, -1);
    chk_mem("busy_start_untouched", 200, 32'd200);
    chk_mem("busy_start_untouched", 201, 32'd201);
  endtask

  task automatic test_back_to_back();
    push_wr(60, 32'h1111_1111);
    run_op(MODE_FILL, 0, 60, 1, 32'h1111_1111, 0, dc, ec, nw, cs);
    chk_int("b2b_first_done", dc, 2);
    push_wr(61, 32'h2222_2222);
    run_op(MODE_FILL, 0, 61, 1, 32'h2222_2222, 0, dc, ec, nw, cs);
    chk_int("b2b_second_done", dc, 2);
  endtask

  task automatic test_reset_mid_copy();
    int n_writes = 0;
    int n_done = 0;
    preload();
    @(negedge clk);
    mode = MODE_COPY; src_addr = 8'd40; dst_addr = 8'd30; length = 9'd4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (mem_write) n_writes++;
      if (c < 4) begin @(posedge clk); #1; end
    end
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, error, mem_write} !== 4'b0 || address !== 32'd0 || write_data !== 32'd0) begin
      failures++;
      $display("FAIL midreset_outputs got flags=%b addr=%h data=%h required 0",
               {busy, done, error, mem_write}, address, write_data);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done || mem_write || busy) n_done++;
    end
    chk_int("midreset_writes_before", n_writes, 2);
    chk_int("midreset_activity_after", n_done, 0);
    chk_mem("midreset_data", 30, 32'd40);
    chk_mem("midreset_data", 31, 32'd41);
    chk_mem("midreset_data", 32, 32'd32);
    chk_mem("midreset_data", 33, 32'd33);
  endtask

  initial begin
    test_reset();
    test_copy();
    test_copy_overlap();
    test_copy_ascending();
    test_fill();
    test_sum();
    test_edge_cases();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_copy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
